writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending write entries; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter ZERO_REG, default 31, meaning the hard-wired zero register index whose writes are discarded.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  a writeback request is present.
REQ-006 in_ready  output  1  the queue can accept a request this cycle.
REQ-007 in_addr  input  5  destination register index.
REQ-008 in_data  input  64  destination register value.
REQ-009 rf_stall  input  1  the register file cannot take a write this cycle.
REQ-010 rf_we  output  1  register-file write enable.
REQ-011 rf_waddr  output  5  register-file write index.
REQ-012 rf_wdata  output  64  register-file write data.
REQ-013 lk1_addr, lk2_addr  input  5 each  operand indices to check against pending writes.
REQ-014 lk1_hit, lk2_hit  output  1 each  a pending entry matches the corresponding lookup.
REQ-015 lk1_data, lk2_data  output  64 each  forwarded value for the corresponding lookup.
REQ-016 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 The queue SHALL be an in-order FIFO of {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-018 in_ready SHALL equal (count != DEPTH), decoded from registered state only.
REQ-019 A request SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-020 An accepted request with in_addr == ZERO_REG SHALL complete the handshake without being enqueued; count SHALL be unchanged by it.
REQ-021 rf_we SHALL equal (count != 0) && !rf_stall, combinationally; rf_waddr and rf_wdata SHALL present the head entry whenever count != 0, else 0.
REQ-022 On a rising edge with rf_we high, the head entry SHALL be popped.
REQ-023 Latency: a request accepted at edge N into an empty queue SHALL drive rf_we in the cycle after edge N, provided rf_stall is low.
REQ-024 Simultaneous push and pop SHALL leave count unchanged. The tail entry SHALL be written, and the head SHALL advance.
REQ-025 When full, no push SHALL occur even if a pop occurs in the same cycle; there is no push-through.
REQ-026 With rf_stall high, the head SHALL be held, and pushes SHALL continue until full.
REQ-027 lkN_hit SHALL be high when any occupied entry's addr equals lkN_addr.
REQ-028 lkN_data SHALL be the data of the youngest matching occupied entry, else 0.
REQ-029 The entry being popped in the current cycle SHALL still count for lookups, since the lookup is combinational on current state.
REQ-030 A lookup of ZERO_REG SHALL never hit.
REQ-031 The incoming request, not yet accepted, SHALL NOT participate in lookup.
REQ-032 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-033 On a rising edge with rst high, head, tail and count SHALL be 0; the rst-high edge SHALL cancel any push or pop presented in that cycle.
REQ-034 Outputs in the cycle after a reset edge: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, lk1_hit=lk2_hit=0, lk1_data=lk2_data=0, count=0.
REQ-035 Entry storage SHALL NOT require reset; stale contents SHALL NOT be observable on any output.
REQ-036 A reset asserted mid-operation, queue partly full with rf_stall high, SHALL discard all pending entries without emitting rf_we.

Verification
REQ-037 Single write: push (addr 5, data 0x0123_4567_89AB_CDEF), rf_stall=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0123_4567_89AB_CDEF; following cycle count=0 and rf_we=0.
REQ-038 Fill and stall: rf_stall=1, push addr 1..5 with data 0x11..0x55 -> after 4 accepts count=4 and in_ready=0; the 5th request is held. Release the stall -> writes appear in order 1,2,3,4, then 5.
REQ-039 Forwarding priority: stall, then push (7,0xAA) and (7,0xBB), with lk1_addr=7 and lk2_addr=8 -> lk1_hit=1, lk1_data=0xBB, lk2_hit=0, lk2_data=0.
REQ-040 Zero register: push (31, 0xFFFF) -> in_ready stays 1, count stays 0, no rf_we; lookup of 31 gives hit=0.
REQ-041 Concurrent push and pop at count=2 over 8 cycles with pointer wrap -> count stays 2, and the write order matches the push order.
REQ-042 Reset mid-fill: 3 entries pending with rf_stall=1, then rst for 1 cycle -> the REQ-034 values hold, and no rf_we occurs after rf_stall drops.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Bundle of the writeback request port, the register-file write port and the
// two forwarding lookups. The queue connects to the slave modport.
interface writeback_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_addr;
  logic [63:0]   in_data;

  logic          rf_stall;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;

  logic [4:0]    lk1_addr;
  logic [4:0]    lk2_addr;
  logic          lk1_hit;
  logic          lk2_hit;
  logic [63:0]   lk1_data;
  logic [63:0]   lk2_data;

  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, rf_stall, lk1_addr, lk2_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
    input  lk1_hit, lk2_hit, lk1_data, lk2_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, rf_stall, lk1_addr, lk2_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata,
    output lk1_hit, lk2_hit, lk1_data, lk2_data, count
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order register writeback queue with youngest-match operand forwarding.
// Writes to the hard-wired zero register are acknowledged and dropped.
module writeback_queue #(
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [4:0]    ZERO_ADDR = 5'(ZERO_REG);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef struct packed {
    logic        hit;
    logic [63:0] data;
  } fwd_t;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [4:0]    addr_mem [DEPTH];
  logic [63:0]   data_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  fwd_t fwd1;
  fwd_t fwd2;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full && (bus.in_addr != ZERO_ADDR);
  assign pop   = !empty && !bus.rf_stall;

  assign bus.in_ready = !full;
  assign bus.rf_we    = pop;
  assign bus.rf_waddr = empty ? 5'd0  : addr_mem[head];
  assign bus.rf_wdata = empty ? 64'd0 : data_mem[head];
  assign bus.count    = count_q;

  // Walk from oldest to youngest so the last match left standing is the youngest.
  function automatic fwd_t lookup(input logic [4:0] key);
    fwd_t          r;
    logic [PW-1:0] idx;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count_q) && (addr_mem[idx] == key) && (key != ZERO_ADDR)) begin
        r.hit  = 1'b1;
        r.data = data_mem[idx];
      end
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    fwd1 = lookup(bus.lk1_addr);
    fwd2 = lookup(bus.lk2_addr);
  end

  assign bus.lk1_hit  = fwd1.hit;
  assign bus.lk1_data = fwd1.data;
  assign bus.lk2_hit  = fwd2.hit;
  assign bus.lk2_data = fwd2.data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage is not reset; occupancy masks stale entries from every output.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      addr_mem[tail] <= bus.in_addr;
      data_mem[tail] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, single write, fill/stall ordering,
// forwarding priority, zero-register drop, concurrent push/pop and mid-fill reset.
module tb_writeback_queue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  writeback_queue_if #(.DEPTH(4)) bus ();

  writeback_queue #(.DEPTH(4), .ZERO_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_addr  = 5'd0;
    bus.in_data  = 64'd0;
    bus.rf_stall = 1'b0;
    bus.lk1_addr = 5'd0;
    bus.lk2_addr = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.lk1_addr = 5'd3;
    bus.lk2_addr = 5'd5;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got %0d want 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_rf_wdata got %h want 0", bus.rf_wdata); end
    checks++; if (bus.lk1_hit !== 1'b0 || bus.lk2_hit !== 1'b0) begin errors++; $display("FAIL reset_lk_hit got %0b%0b want 00", bus.lk1_hit, bus.lk2_hit); end
    checks++; if (bus.lk1_data !== 64'd0 || bus.lk2_data !== 64'd0) begin errors++; $display("FAIL reset_lk_data got %h %h want 0 0", bus.lk1_data, bus.lk2_data); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
  endtask

  task automatic test_single_write();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 64'h0123_4567_89AB_CDEF;
    bus.lk1_addr = 5'd5;
    #1;
    checks++; if (bus.lk1_hit !== 1'b0) begin errors++; $display("FAIL single_incoming_not_forwarded got %0b want 0", bus.lk1_hit); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL single_rf_we got %0b want 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL single_rf_waddr got %0d want 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL single_rf_wdata got %h want 0123456789abcdef", bus.rf_wdata); end
    checks++; if (bus.lk1_hit !== 1'b1 || bus.lk1_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL single_popping_forward got %0b %h want 1 0123456789abcdef", bus.lk1_hit, bus.lk1_data); end
    tick();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL single_count_after got %0d want 0", bus.count); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL single_rf_we_after got %0b want 0", bus.rf_we); end
  endtask

  task automatic test_fill_stall();
    idle_inputs();
    bus.rf_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'(i);
      bus.in_data  = 64'(i * 17);
      #1;
      checks++; if (bus.in_ready !== (i <= 4)) begin errors++; $display("FAIL fill_in_ready_%0d got %0b want %0b", i, bus.in_ready, (i <= 4)); end
      tick();
    end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full got %0b want 0", bus.in_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL fill_rf_we_stalled got %0b want 0", bus.rf_we); end
    bus.rf_stall = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(k) || bus.rf_wdata !== 64'(k * 17)) begin
        errors++; $display("FAIL drain_order_%0d got we=%0b addr=%0d data=%h want we=1 addr=%0d data=%h", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, k, 64'(k * 17));
      end
      if (k == 1) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL no_push_through got in_ready=%0b want 0", bus.in_ready); end
      end
      tick();
      if (k == 1) begin
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", bus.count); end
      end
      if (k == 2) bus.in_valid = 1'b0;
    end
    checks++; if (bus.count !== 3'd0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL fill_drained got count=%0d we=%0b want 0 0", bus.count, bus.rf_we); end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    bus.rf_stall = 1'b1;
    bus.lk1_addr = 5'd7;
    bus.lk2_addr = 5'd8;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd7;
    bus.in_data  = 64'hAA;
    tick();
    bus.in_data  = 64'hBB;
    #1;
    checks++; if (bus.lk1_hit !== 1'b1 || bus.lk1_data !== 64'hAA) begin errors++; $display("FAIL fwd_before_second got %0b %h want 1 aa", bus.lk1_hit, bus.lk1_data); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.lk1_hit !== 1'b1 || bus.lk1_data !== 64'hBB) begin errors++; $display("FAIL fwd_youngest got %0b %h want 1 bb", bus.lk1_hit, bus.lk1_data); end
    checks++; if (bus.lk2_hit !== 1'b0 || bus.lk2_data !== 64'd0) begin errors++; $display("FAIL fwd_miss got %0b %h want 0 0", bus.lk2_hit, bus.lk2_data); end
    bus.rf_stall = 1'b0;
    tick();
    checks++; if (bus.lk1_data !== 64'hBB || bus.rf_wdata !== 64'hBB) begin errors++; $display("FAIL fwd_after_pop got lk=%h head=%h want bb bb", bus.lk1_data, bus.rf_wdata); end
    tick();
    checks++; if (bus.count !== 3'd0 || bus.lk1_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got count=%0d hit=%0b want 0 0", bus.count, bus.lk1_hit); end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd31;
    bus.in_data  = 64'hFFFF;
    bus.lk1_addr = 5'd31;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL zero_count got %0d want 0", bus.count); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_rf_we got %0b want 0", bus.rf_we); end
    checks++; if (bus.lk1_hit !== 1'b0 || bus.lk1_data !== 64'd0) begin errors++; $display("FAIL zero_lookup got %0b %h want 0 0", bus.lk1_hit, bus.lk1_data); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.rf_stall = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_addr = 5'(10 + i);
      bus.in_data = 64'((10 + i) * 257);
      tick();
    end
    bus.rf_stall = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bus.in_valid = (j < 8);
      bus.in_addr  = 5'(12 + j);
      bus.in_data  = 64'((12 + j) * 257);
      #1;
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(10 + j) || bus.rf_wdata !== 64'((10 + j) * 257)) begin
        errors++; $display("FAIL b2b_order_%0d got we=%0b addr=%0d data=%h want we=1 addr=%0d", j, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 10 + j);
      end
      if (j < 8) begin
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d got %0d want 2", j, bus.count); end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_reset_mid_fill();
    idle_inputs();
    bus.rf_stall = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_addr = 5'(i);
      bus.in_data = 64'(i);
      tick();
    end
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL midrst_pre_count got %0d want 3", bus.count); end
    bus.in_addr = 5'd4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.lk1_addr = 5'd1;
    bus.lk2_addr = 5'd4;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_state got count=%0d ready=%0b want 0 1", bus.count, bus.in_ready); end
    checks++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 64'd0) begin errors++; $display("FAIL midrst_head got %0d %h want 0 0", bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.lk1_hit !== 1'b0 || bus.lk2_hit !== 1'b0 || bus.lk1_data !== 64'd0 || bus.lk2_data !== 64'd0) begin
      errors++; $display("FAIL midrst_lookup got %0b %0b %h %h want 0 0 0 0", bus.lk1_hit, bus.lk2_hit, bus.lk1_data, bus.lk2_data);
    end
    bus.rf_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midrst_no_write_%0d got %0b want 0", k, bus.rf_we); end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_fill_stall();
    test_forwarding();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
